int_to_minifloat: RTL and testbench

//  Multi-cycle encoder: signed two's-complement integer -> 1/EXP_W/MANTISSA_W minifloat.

---
 rtl/minifloat_pkg.sv | 28 ++
 rtl/int_to_minifloat_if.sv | 26 ++
 rtl/minifloat_round.sv | 45 ++++
 rtl/int_to_minifloat.sv | 99 +++++++++
 tb/tb_int_to_minifloat.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/minifloat_pkg.sv
// Shared minifloat format: field widths, bias, flag layout, FSM states.
// Used by the integer encoder and the float ALU result path.
package minifloat_pkg;

    localparam int EXP_W      = 4;
    localparam int MANTISSA_W = 3;
    localparam int WIDTH      = 1 + EXP_W + MANTISSA_W;
    localparam int BIAS       = 2 ** (EXP_W - 1) - 1;
    localparam int EXP_INF    = 2 ** EXP_W - 1;

    localparam int FLG_OVF  = 2;
    localparam int FLG_ZERO = 1;
    localparam int FLG_NEG  = 0;

    typedef struct packed {
        logic                  sign;
        logic [EXP_W-1:0]      exp;
        logic [MANTISSA_W-1:0] mant;
    } minifloat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/int_to_minifloat_if.sv
// Valid/ready bundle between the integer datapath and the encoder.
// slave = encoder side, master = producer/consumer side.
interface int_to_minifloat_if #(
    parameter int INT_W = 16
);
    import minifloat_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [INT_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    minifloat_t       result;
    logic [2:0]       flags;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, result, flags
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/minifloat_round.sv
// Round-to-nearest-even, exponent bias and inf saturation for a
// normalised magnitude whose hidden 1 sits just above frac.
module minifloat_round
    import minifloat_pkg::*;
#(
    parameter int IN_W = 16,
    parameter int EW   = 5
) (
    input  logic            sign,
    input  logic [IN_W-2:0] frac,
    input  logic [EW-1:0]   e,
    output minifloat_t      result,
    output logic            ovf
);

    localparam int FW = IN_W - 1;
    localparam int BW = ((EW > EXP_W) ? EW : EXP_W) + 2;

    logic [MANTISSA_W-1:0] m;
    logic                  guard;
    logic                  sticky;
    logic                  up;
    logic [MANTISSA_W:0]   m_r;
    logic [BW-1:0]         be;

    // RNE on the kept bits, carry bumps exponent, saturate past max finite
    always_comb begin
        m      = frac[FW-1 -: MANTISSA_W];
        guard  = frac[FW-1-MANTISSA_W];
        sticky = |frac[FW-2-MANTISSA_W:0];
        up     = guard & (sticky | m[0]);
        m_r    = {1'b0, m} + (MANTISSA_W+1)'(up);
        be     = BW'(e) + BW'(BIAS) + BW'(m_r[MANTISSA_W]);
        ovf    = be > BW'(EXP_INF - 1);
        result.sign = sign;
        if (ovf) begin
            result.exp  = EXP_W'(EXP_INF);
            result.mant = '0;
        end else begin
            result.exp  = be[EXP_W-1:0];
            result.mant = m_r[MANTISSA_W-1:0];
        end
    end

endmodule

// File: rtl/int_to_minifloat.sv
// Multi-cycle signed integer to minifloat encoder, one conversion
// in flight, normalising one bit per cycle.
module int_to_minifloat
    import minifloat_pkg::*;
#(
    parameter int INT_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    int_to_minifloat_if.slave bus
);

    localparam int EW = $clog2(INT_W) + 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_NORM  = NORM;
    localparam logic [1:0] ST_ROUND = ROUND;
    localparam logic [1:0] ST_OUT   = OUT;

    logic [1:0]           state;
    logic                 sign;
    logic [INT_W-1:0]     mag;
    logic [INT_W-1:0]     abs_in;
    logic signed [EW-1:0] e;
    minifloat_t           rnd_res;
    logic                 rnd_ovf;
    minifloat_t           result_q;
    logic [2:0]           flags_q;

    // most negative input wraps to 2**(INT_W-1), which fits unsigned
    assign abs_in = bus.in_data[INT_W-1] ? (~bus.in_data + 1'b1)
                                         : bus.in_data;

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_OUT);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    minifloat_round #(
        .IN_W (INT_W),
        .EW   (EW)
    ) u_round (
        .sign   (sign),
        .frac   (mag[INT_W-2:0]),
        .e      (e),
        .result (rnd_res),
        .ovf    (rnd_ovf)
    );

    // conversion FSM: capture, shift until MSB set, round, hold result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sign     <= 1'b0;
            mag      <= '0;
            e        <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        sign <= bus.in_data[INT_W-1];
                        mag  <= abs_in;
                        e    <= EW'(INT_W - 1);
                        if (abs_in == '0) begin
                            result_q          <= '0;
                            flags_q           <= '0;
                            flags_q[FLG_ZERO] <= 1'b1;
                            state             <= ST_OUT;
                        end else begin
                            state <= ST_NORM;
                        end
                    end
                end
                ST_NORM: begin
                    if (!mag[INT_W-1]) begin
                        mag <= mag << 1;
                        e   <= e - 1'b1;
                    end else begin
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    result_q          <= rnd_res;
                    flags_q[FLG_OVF]  <= rnd_ovf;
                    flags_q[FLG_ZERO] <= 1'b0;
                    flags_q[FLG_NEG]  <= sign;
                    state             <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_minifloat.sv
// Self-checking bench for int_to_minifloat: directed spec values,
// random values against an arithmetic model, handshake and reset.
module tb_int_to_minifloat;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    int_to_minifloat_if #(.INT_W(16)) bus ();

    int_to_minifloat #(.INT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference: exact magnitude, RNE with integer remainder arithmetic
    function automatic void model(input logic [15:0] v,
                                  output logic [7:0] r,
                                  output logic [2:0] f,
                                  output int edges);
        int a, e, q, sh, rem, half, be;
        logic s;
        s = v[15];
        a = s ? 65536 - int'(v) : int'(v);
        if (a == 0) begin
            r = 8'h00; f = 3'b010; edges = 0;
            return;
        end
        e = 0;
        while ((a >> (e + 1)) != 0) e++;
        edges = (15 - e) + 2;
        if (e <= 3) begin
            q = a << (3 - e);
        end else begin
            sh   = e - 3;
            q    = a >> sh;
            rem  = a - (q << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
        end
        if (q == 16) begin
            q = 8; e++;
        end
        be = e + 7;
        if (be > 14) begin
            r = {s, 7'b1111000}; f = {1'b1, 1'b0, s};
        end else begin
            r = {s, 4'(be), 3'(q)}; f = {2'b00, s};
        end
    endfunction

    task automatic accept(input logic [15:0] v, output int edges,
                          output logic ok);
        int w = 0;
        while (!bus.in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        edges = 0;
        while (!bus.out_valid && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
        ok = bus.out_valid;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'd9;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (bus.out_valid !== 1'b0 || bus.result !== 8'h00 ||
            bus.flags !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_state: got v=%b r=%h f=%b want 0 00 000",
                     bus.out_valid, bus.result, bus.flags);
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle: got rdy=%b v=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] vals [11] = '{16'd1, 16'hFFFF, 16'd0, 16'd9,
                                   16'd17, 16'd19, 16'd247, 16'd240,
                                   16'd248, 16'h8000, 16'd32767};
        logic [7:0]  er [11] = '{8'h38, 8'hB8, 8'h00, 8'h51, 8'h58,
                                 8'h5A, 8'h77, 8'h77, 8'h78, 8'hF8,
                                 8'h78};
        logic [2:0]  ef [11] = '{3'b000, 3'b001, 3'b010, 3'b000,
                                 3'b000, 3'b000, 3'b000, 3'b000,
                                 3'b100, 3'b101, 3'b100};
        int          el [11] = '{17, 17, 0, 14, 13, 13, 10, 10, 10,
                                 2, 3};
        int   edges;
        logic ok;
        for (int i = 0; i < 11; i++) begin
            accept(vals[i], edges, ok);
            compared++;
            if (!ok || bus.result !== er[i]) begin
                mismatched++;
                $display("FAIL dir_result in=%h: got %h want %h",
                         vals[i], bus.result, er[i]);
            end
            compared++;
            if (bus.flags !== ef[i]) begin
                mismatched++;
                $display("FAIL dir_flags in=%h: got %b want %b",
                         vals[i], bus.flags, ef[i]);
            end
            compared++;
            if (edges != el[i]) begin
                mismatched++;
                $display("FAIL dir_latency in=%h: got %0d want %0d",
                         vals[i], edges, el[i]);
            end
            release_out();
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic [7:0]  r;
        logic [2:0]  f;
        int          el, edges;
        logic        ok;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                v = 16'($urandom);
            end else begin
                v = 16'($urandom_range(1, 600));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            if ($urandom_range(0, 9) == 0) v = 16'd0;
            model(v, r, f, el);
            accept(v, edges, ok);
            compared++;
            if (!ok || bus.result !== r || bus.flags !== f ||
                edges != el) begin
                mismatched++;
                $display("FAIL rand in=%h: got %h/%b/%0d want %h/%b/%0d",
                         v, bus.result, bus.flags, edges, r, f, el);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            release_out();
        end
    endtask

    task automatic test_hold();
        int   edges;
        logic ok;
        accept(16'd247, edges, ok);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'd9;
            @(posedge clk); #1;
            compared++;
            if (bus.out_valid !== 1'b1 || bus.result !== 8'h77 ||
                bus.in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL hold cyc=%0d: got v=%b r=%h rdy=%b want 1 77 0",
                         i, bus.out_valid, bus.result, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        release_out();
        compared++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL hold_release: got rdy=%b v=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_ignore();
        int w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (bus.in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL ign_busy: got rdy=%b want 0", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && w < 40) begin
            @(posedge clk); #1; w++;
        end
        compared++;
        if (bus.out_valid !== 1'b1 || bus.result !== 8'h38 ||
            bus.flags !== 3'b000) begin
            mismatched++;
            $display("FAIL ign_result: got v=%b r=%h f=%b want 1 38 000",
                     bus.out_valid, bus.result, bus.flags);
        end
        release_out();
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ign_latched: got v=%b rdy=%b want 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int   edges;
        logic ok;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_abort: got v=%b rdy=%b want 0 1",
                     bus.out_valid, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd19;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        compared++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.result !== 8'h00) begin
            mismatched++;
            $display("FAIL rst_no_output: got v=%b rdy=%b r=%h want 0 1 00",
                     bus.out_valid, bus.in_ready, bus.result);
        end
        accept(16'd9, edges, ok);
        compared++;
        if (!ok || bus.result !== 8'h51 || bus.flags !== 3'b000) begin
            mismatched++;
            $display("FAIL rst_fresh: got %h/%b want 51/000",
                     bus.result, bus.flags);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        logic [7:0]  r;
        logic [2:0]  f;
        int          el, edges;
        logic        ok;
        for (int i = 0; i < 8; i++) begin
            v = 16'($urandom);
            model(v, r, f, el);
            accept(v, edges, ok);
            compared++;
            if (!ok || bus.result !== r || bus.flags !== f) begin
                mismatched++;
                $display("FAIL b2b in=%h: got %h/%b want %h/%b",
                         v, bus.result, bus.flags, r, f);
            end
            release_out();
            compared++;
            if (bus.in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL b2b_ready: got %b want 1", bus.in_ready);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
